// File: rtl/meikyuu_pkg.sv
// rtl/meikyuu_pkg.sv - shared types, colours and wall geometry for the maze room engine
//
// Purpose: open-side bit indices, 24-bit colours {R,G,B}, the move direction
// and move FSM enums, and the wall-overlap test used by both the pixel path
// (1x1 box) and the player collision check (PSIZE x PSIZE box).
package meikyuu_pkg;

    localparam int OPEN_N = 0;
    localparam int OPEN_E = 1;
    localparam int OPEN_S = 2;
    localparam int OPEN_W = 3;

    localparam logic [23:0] COL_PLAYER = {8'd153, 8'd51, 8'd153};
    localparam logic [23:0] COL_WALL   = {8'd36, 8'd60, 8'd0};
    localparam logic [23:0] COL_FLOOR  = 24'h000000;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMMIT,
        ST_TRANSIT
    } move_state_e;

    // True when box [x0,x1]x[y0,y1] touches a corner square or a closed side band.
    function automatic logic wall_hit(input int x0, input int y0,
                                      input int x1, input int y1,
                                      input logic [3:0] mask,
                                      input int wall, input int act_w, input int act_h);
        logic in_w, in_e, in_n, in_s;
        in_w = (x0 < wall);
        in_e = (x1 >= act_w - wall);
        in_n = (y0 < wall);
        in_s = (y1 >= act_h - wall);
        return ((in_w || in_e) && (in_n || in_s))
            || (in_n && !mask[OPEN_N]) || (in_s && !mask[OPEN_S])
            || (in_w && !mask[OPEN_W]) || (in_e && !mask[OPEN_E]);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-enable tick, raster counters and raw sync for the maze display
//
// Purpose: divides CLOCK_50 into a one-cycle-in-two pixel enable and walks the
// h/v raster. Outputs are combinational from the counters; the top registers them.
// Ports:
//   CLOCK_50, reset  clock, async active-high reset
//   tick_o           pixel enable (also the 25 MHz pixel clock)
//   h_o, v_o         raster position; equals active-area x/y while active_o
//   active_o         inside the visible area
//   hs_n_o, vs_n_o   unregistered active-low syncs
//   frame_tick_o     one-cycle pulse at the first blanking line (v==V_ACT, h==0)
module vga_timing_gen #(
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic       tick_o,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       active_o,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       frame_tick_o
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    logic       tick_q;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            tick_q <= ~tick_q;
            h_q    <= h_d;
            v_q    <= v_d;
        end
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick_q) begin
            if (h_q == 10'(H_TOT - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    assign tick_o       = tick_q;
    assign h_o          = h_q;
    assign v_o          = v_q;
    assign active_o     = (h_q < 10'(H_ACT)) && (v_q < 10'(V_ACT));
    assign hs_n_o       = !((h_q >= 10'(H_ACT + H_FP)) && (h_q < 10'(H_ACT + H_FP + H_SYNC)));
    assign vs_n_o       = !((v_q >= 10'(V_ACT + V_FP)) && (v_q < 10'(V_ACT + V_FP + V_SYNC)));
    assign frame_tick_o = tick_q && (v_q == 10'(V_ACT)) && (h_q == '0);

endmodule

// File: rtl/maze_room_engine.sv
// rtl/maze_room_engine.sv - maze room renderer and once-per-frame player mover
//
// Purpose: holds the GRID_W x GRID_H map of open-side masks, draws the current
// room and player sprite, and moves the player with collision and room transits.
// Ports:
//   CLOCK_50, reset                 clock, async active-high reset
//   btn_up/down/left/right          asynchronous buttons, active-high
//   map_we, map_wx, map_wy, map_wdata  map tile write (bit0=N,1=E,2=S,3=W, 1=open)
//   VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK  video output
//   room_x, room_y                  current room
//   player_x, player_y              player top-left in active-area pixels
module maze_room_engine
    import meikyuu_pkg::*;
#(
    parameter int GRID_W = 3,
    parameter int GRID_H = 3,
    parameter int WALL   = 100,
    parameter int PSIZE  = 16,
    parameter int STEP   = 4,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      map_we,
    input  logic [$clog2(GRID_W)-1:0] map_wx,
    input  logic [$clog2(GRID_H)-1:0] map_wy,
    input  logic [3:0]                map_wdata,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic                      VGA_BLANK_N,
    output logic                      VGA_SYNC_N,
    output logic                      VGA_CLK,
    output logic [$clog2(GRID_W)-1:0] room_x,
    output logic [$clog2(GRID_H)-1:0] room_y,
    output logic [9:0]                player_x,
    output logic [9:0]                player_y
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [9:0] PX_RST = 10'((H_ACT - PSIZE) / 2);
    localparam logic [9:0] PY_RST = 10'((V_ACT - PSIZE) / 2);

    logic       tick, active, hs_n, vs_n, frame_tick;
    logic [9:0] h, v;

    vga_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .tick_o      (tick),
        .h_o         (h),
        .v_o         (v),
        .active_o    (active),
        .hs_n_o      (hs_n),
        .vs_n_o      (vs_n),
        .frame_tick_o(frame_tick)
    );

    // Buttons packed as {right, left, down, up}.
    logic [3:0] btn_s1_q, btn_s2_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            btn_s1_q <= {btn_right, btn_left, btn_down, btn_up};
            btn_s2_q <= btn_s1_q;
        end
    end

    logic [3:0] map_q [GRID_H][GRID_W];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < GRID_H; r++) begin
                for (int c = 0; c < GRID_W; c++) begin
                    map_q[r][c] <= 4'hF;
                end
            end
        end else if (map_we && (int'(map_wx) < GRID_W) && (int'(map_wy) < GRID_H)) begin
            map_q[map_wy][map_wx] <= map_wdata;
        end
    end

    logic [XW-1:0] room_x_q;
    logic [YW-1:0] room_y_q;
    logic [9:0]    player_x_q, player_y_q;
    logic [3:0]    cur_mask;

    // Read live so a rewrite of the current room shows from the next pixel.
    assign cur_mask = map_q[room_y_q][room_x_q];

    // Pixel path: one registered stage shared by colour, syncs and blank.
    logic        pix_player, pix_wall;
    logic [23:0] pix_rgb;
    logic [23:0] rgb_q;
    logic        hs_q, vs_q, blank_q;

    always_comb begin
        pix_player = (int'(h) >= int'(player_x_q)) && (int'(h) < int'(player_x_q) + PSIZE)
                  && (int'(v) >= int'(player_y_q)) && (int'(v) < int'(player_y_q) + PSIZE);
        pix_wall   = wall_hit(int'(h), int'(v), int'(h), int'(v), cur_mask, WALL, H_ACT, V_ACT);
        if (!active) begin
            pix_rgb = 24'h000000;
        end else if (pix_player) begin
            pix_rgb = COL_PLAYER;
        end else if (pix_wall) begin
            pix_rgb = COL_WALL;
        end else begin
            pix_rgb = COL_FLOOR;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else if (tick) begin
            rgb_q   <= pix_rgb;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            blank_q <= active;
        end
    end

    // Move FSM.
    move_state_e state_q, state_d;
    dir_e        dir_q, dir_sel;
    logic [9:0]  cand_x, cand_y, cand_x_q, cand_y_q;
    logic        off_edge, side_open, nbr_ok, box_hit;
    logic        latch_dir, load_cand, do_commit, do_transit;

    always_comb begin
        if (btn_s2_q[0])      dir_sel = DIR_N;
        else if (btn_s2_q[1]) dir_sel = DIR_S;
        else if (btn_s2_q[2]) dir_sel = DIR_W;
        else if (btn_s2_q[3]) dir_sel = DIR_E;
        else                  dir_sel = DIR_NONE;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        cand_x    = player_x_q;
        cand_y    = player_y_q;
        off_edge  = 1'b0;
        side_open = 1'b0;
        nbr_ok    = 1'b0;
        case (dir_q)
            DIR_N: begin
                off_edge  = int'(player_y_q) < STEP;
                side_open = cur_mask[OPEN_N];
                nbr_ok    = room_y_q != '0;
                cand_y    = player_y_q - 10'(STEP);
            end
            DIR_S: begin
                off_edge  = int'(player_y_q) + PSIZE + STEP > V_ACT;
                side_open = cur_mask[OPEN_S];
                nbr_ok    = int'(room_y_q) < GRID_H - 1;
                cand_y    = player_y_q + 10'(STEP);
            end
            DIR_W: begin
                off_edge  = int'(player_x_q) < STEP;
                side_open = cur_mask[OPEN_W];
                nbr_ok    = room_x_q != '0;
                cand_x    = player_x_q - 10'(STEP);
            end
            DIR_E: begin
                off_edge  = int'(player_x_q) + PSIZE + STEP > H_ACT;
                side_open = cur_mask[OPEN_E];
                nbr_ok    = int'(room_x_q) < GRID_W - 1;
                cand_x    = player_x_q + 10'(STEP);
            end
            default: ;
        endcase
        // Only meaningful when off_edge is clear, so wrapped candidates never matter.
        box_hit = wall_hit(int'(cand_x), int'(cand_y), int'(cand_x) + PSIZE - 1,
                           int'(cand_y) + PSIZE - 1, cur_mask, WALL, H_ACT, V_ACT);

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick && (dir_sel != DIR_NONE)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (off_edge) state_d = (side_open && nbr_ok) ? ST_TRANSIT : ST_IDLE;
                else          state_d = box_hit ? ST_IDLE : ST_COMMIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_dir  = (state_q == ST_IDLE) && (state_d == ST_CHECK);
        load_cand  = (state_q == ST_CHECK);
        do_commit  = (state_q == ST_COMMIT);
        do_transit = (state_q == ST_TRANSIT);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dir_q      <= DIR_NONE;
            cand_x_q   <= PX_RST;
            cand_y_q   <= PY_RST;
            player_x_q <= PX_RST;
            player_y_q <= PY_RST;
            room_x_q   <= '0;
            room_y_q   <= '0;
        end else begin
            if (latch_dir) dir_q <= dir_sel;
            if (load_cand) begin
                cand_x_q <= cand_x;
                cand_y_q <= cand_y;
            end
            if (do_commit) begin
                player_x_q <= cand_x_q;
                player_y_q <= cand_y_q;
            end
            if (do_transit) begin
                // Enter the neighbour at the edge opposite the one we left.
                case (dir_q)
                    DIR_N: begin
                        room_y_q   <= room_y_q - YW'(1);
                        player_y_q <= 10'(V_ACT - PSIZE);
                    end
                    DIR_S: begin
                        room_y_q   <= room_y_q + YW'(1);
                        player_y_q <= '0;
                    end
                    DIR_E: begin
                        room_x_q   <= room_x_q + XW'(1);
                        player_x_q <= '0;
                    end
                    DIR_W: begin
                        room_x_q   <= room_x_q - XW'(1);
                        player_x_q <= 10'(H_ACT - PSIZE);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = tick;
    assign room_x      = room_x_q;
    assign room_y      = room_y_q;
    assign player_x    = player_x_q;
    assign player_y    = player_y_q;

endmodule

// File: tb/tb_maze_room_engine.sv
// tb/tb_maze_room_engine.sv - scoreboard bench for maze_room_engine on a reduced raster
`timescale 1ns/1ps
module tb_maze_room_engine;

    localparam int H_ACT = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_ACT = 24, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int WALL = 6, PSIZE = 4, STEP = 2;
    localparam int H_TOT = 40, V_TOT = 28;
    localparam int FRAME_CYC = 2 * H_TOT * V_TOT;
    localparam int X0 = 14, Y0 = 10;

    localparam logic [23:0] GREEN  = 24'h243C00;
    localparam logic [23:0] PURPLE = 24'h993399;
    localparam logic [23:0] BLACK  = 24'h000000;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic       map_we = 0;
    logic [1:0] map_wx = 0, map_wy = 0;
    logic [3:0] map_wdata = 0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic [1:0] room_x, room_y;
    logic [9:0] player_x, player_y;

    always #10 CLOCK_50 = ~CLOCK_50;

    maze_room_engine #(
        .GRID_W(3), .GRID_H(3), .WALL(WALL), .PSIZE(PSIZE), .STEP(STEP),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .map_we(map_we), .map_wx(map_wx), .map_wy(map_wy), .map_wdata(map_wdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
        .room_x(room_x), .room_y(room_y), .player_x(player_x), .player_y(player_y)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // sel: 0 player_x, 1 player_y, 2 room_x, 3 room_y, 4 packed RGB
    typedef struct {
        int    key;
        int    sel;
        int    exp;
        string tag;
    } sb_t;
    sb_t sbq[$];

    task automatic sb_push(input int key, input int sel, input int exp, input string tag);
        sb_t e;
        e.key = key; e.sel = sel; e.exp = exp; e.tag = tag;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return 32'(player_x);
            1:       return 32'(player_y);
            2:       return 32'(room_x);
            3:       return 32'(room_y);
            default: return {8'd0, VGA_R, VGA_G, VGA_B};
        endcase
    endfunction

    task automatic sb_drain(input int key);
        sb_t e;
        while (sbq.size() > 0 && sbq[0].key == key) begin
            e = sbq.pop_front();
            check_val($sformatf("%s k%0d", e.tag, key), obs(e.sel), 32'(e.exp));
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return VGA_HS;
            1:       return VGA_VS;
            default: return VGA_BLANK_N;
        endcase
    endfunction

    // Waits (at negedges) for sig(sel) to transition to lvl; bounded.
    task automatic wait_edge(input int sel, input logic lvl);
        logic prev, cur;
        bit   ok;
        ok   = 0;
        prev = sig(sel);
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            @(negedge CLOCK_50);
            cur = sig(sel);
            if (cur == lvl && prev != lvl) begin
                ok = 1;
                break;
            end
            prev = cur;
        end
        if (!ok) check_val($sformatf("timeout_sig%0d", sel), 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; map_we = 0;
        @(negedge CLOCK_50);
        reset = 1;
        repeat (3) @(negedge CLOCK_50);
        reset = 0;
    endtask

    task automatic map_write(input int x, input int y, input logic [3:0] d);
        map_wx = 2'(x); map_wy = 2'(y); map_wdata = d; map_we = 1;
        @(negedge CLOCK_50);
        map_we = 0;
    endtask

    task automatic run_frames(input int nf);
        for (int k = 1; k <= nf; k++) begin
            wait_edge(1, 1'b0);
            sb_drain(k);
        end
    endtask

    // Lands on the negedge where pixel (0,y) is on the outputs.
    task automatic wait_line(input int y);
        wait_edge(1, 1'b1);
        for (int i = 0; i <= y; i++) wait_edge(2, 1'b1);
    endtask

    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    logic hs_p, vs_p, bl_p;
    bit   first_px;
    int   lines;

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check_val("rst_hs", 32'(VGA_HS), 32'd1);
        check_val("rst_vs", 32'(VGA_VS), 32'd1);
        check_val("rst_blank", 32'(VGA_BLANK_N), 32'd0);
        check_val("rst_sync_n", 32'(VGA_SYNC_N), 32'd0);
        check_val("rst_px", 32'(player_x), X0);
        check_val("rst_py", 32'(player_y), Y0);
        check_val("rst_room_x", 32'(room_x), 0);
        check_val("rst_room_y", 32'(room_y), 0);

        // Raster timing and pixel (0,0) over two frames
        reset = 0;
        hs_p = VGA_HS; vs_p = VGA_VS; bl_p = VGA_BLANK_N; first_px = 1;
        sb_push(100, 4, GREEN, "px00_corner");
        for (int cyc = 1; cyc <= 2 * FRAME_CYC + 200; cyc++) begin
            @(negedge CLOCK_50);
            if (hs_p && !VGA_HS) hs_fall.push_back(cyc);
            if (!hs_p && VGA_HS) hs_rise.push_back(cyc);
            if (vs_p && !VGA_VS) vs_fall.push_back(cyc);
            if (!vs_p && VGA_VS) vs_rise.push_back(cyc);
            if (!bl_p && VGA_BLANK_N && first_px) begin
                first_px = 0;
                sb_drain(100);
            end
            hs_p = VGA_HS; vs_p = VGA_VS; bl_p = VGA_BLANK_N;
        end
        check_val("hs_edges_seen", 32'(hs_fall.size() >= 2 && hs_rise.size() >= 1), 1);
        check_val("vs_edges_seen", 32'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 1);
        if (hs_fall.size() >= 2 && hs_rise.size() >= 1 && vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
            check_val("hs_low_ticks", 32'((hs_rise[0] - hs_fall[0]) / 2), H_SYNC);
            check_val("line_ticks", 32'((hs_fall[1] - hs_fall[0]) / 2), H_TOT);
            check_val("vs_low_lines", 32'((vs_rise[0] - vs_fall[0]) / (2 * H_TOT)), V_SYNC);
            check_val("frame_ticks", 32'((vs_fall[1] - vs_fall[0]) / 2), H_TOT * V_TOT);
            lines = 0;
            foreach (hs_fall[i]) if (hs_fall[i] >= vs_fall[0] && hs_fall[i] < vs_fall[1]) lines++;
            check_val("lines_per_frame", 32'(lines), V_TOT);
        end

        // Closed room: walk left into the west wall
        do_reset();
        map_write(0, 0, 4'h0);
        btn_left = 1;
        for (int k = 1; k <= 6; k++) begin
            sb_push(k, 0, (X0 - STEP * k < WALL) ? WALL : X0 - STEP * k, "left_x");
            sb_push(k, 1, Y0, "left_y");
        end
        run_frames(6);
        btn_left = 0;

        // Vertical corridor: walk down and into room (0,1)
        do_reset();
        map_write(0, 0, 4'h5);
        map_write(0, 1, 4'h5);
        btn_down = 1;
        for (int k = 1; k <= 5; k++) begin
            sb_push(k, 1, Y0 + STEP * k, "down_y");
            sb_push(k, 3, 0, "down_room_y");
        end
        sb_push(6, 1, 0, "transit_y");
        sb_push(6, 3, 1, "transit_room_y");
        sb_push(6, 0, X0, "transit_x");
        sb_push(6, 2, 0, "transit_room_x");
        sb_push(7, 1, STEP, "after_transit_y");
        sb_push(7, 3, 1, "after_transit_room_y");
        run_frames(7);
        btn_down = 0;

        // Top of the map: open north side but no neighbour
        do_reset();
        map_write(0, 0, 4'h5);
        btn_up = 1;
        for (int k = 1; k <= 7; k++) begin
            sb_push(k, 1, (k <= 5) ? Y0 - STEP * k : 0, "up_y");
            sb_push(k, 3, 0, "up_room_y");
        end
        run_frames(7);
        btn_up = 0;

        // Up beats right
        do_reset();
        btn_up = 1; btn_right = 1;
        for (int k = 1; k <= 2; k++) begin
            sb_push(k, 1, Y0 - STEP * k, "upright_y");
            sb_push(k, 0, X0, "upright_x");
        end
        run_frames(2);
        btn_up = 0; btn_right = 0;

        // Reset after a move restores the centred player
        do_reset();
        check_val("rerst_px", 32'(player_x), X0);
        check_val("rerst_py", 32'(player_y), Y0);

        // Mid-frame rewrite of the current room
        wait_line(2);
        repeat (2 * 16) @(negedge CLOCK_50);
        sb_push(200, 4, BLACK, "px_16_2_open");
        sb_drain(200);
        for (int i = 3; i <= 11; i++) wait_edge(2, 1'b1);
        repeat (2 * 15) @(negedge CLOCK_50);
        sb_push(201, 4, PURPLE, "px_player");
        sb_drain(201);
        for (int i = 12; i <= 15; i++) wait_edge(2, 1'b1);
        map_write(0, 0, 4'h0);
        repeat (2 * 28 - 1) @(negedge CLOCK_50);
        sb_push(202, 4, GREEN, "px_28_15_after_write");
        sb_drain(202);
        wait_line(2);
        repeat (2 * 16) @(negedge CLOCK_50);
        sb_push(203, 4, GREEN, "px_16_2_closed");
        sb_drain(203);

        // Reset reverts the map to all-open
        do_reset();
        wait_line(2);
        repeat (2 * 16) @(negedge CLOCK_50);
        sb_push(204, 4, BLACK, "px_16_2_map_reset");
        sb_drain(204);

        check_val("sb_leftover", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_room_engine.md
Name: maze_room_engine

Overview:
Next-generation maze renderer and player controller for the VGA maze game. It holds a GRID_W x GRID_H room map of 4-bit open-side masks, so all 16 room shapes are available. It generates parametrised VGA timing and draws the current room and the player sprite. Once per frame, an FSM moves the player with wall collision and room-to-room transitions; the map can be rewritten at runtime.

Parameters:
GRID_W, 3, map columns (rooms)
GRID_H, 3, map rows (rooms)
WALL, 100, wall band thickness in pixels
PSIZE, 16, player square side in pixels
STEP, 4, pixels moved per frame
H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
CLOCK_50  in  1  system clock
reset  in  1  async active-high reset
btn_up/btn_down/btn_left/btn_right  in  1 each  async buttons, active-high
map_we  in  1  map write strobe
map_wx  in  clog2(GRID_W)  write column
map_wy  in  clog2(GRID_H)  write row
map_wdata  in  4  open mask; bit0=N, 1=E, 2=S, 3=W; bit set = open
VGA_R/VGA_G/VGA_B  out  8 each  pixel colour
VGA_HS/VGA_VS  out  1 each  sync, active-low
VGA_BLANK_N  out  1  high during active video
VGA_SYNC_N  out  1  constant 0
VGA_CLK  out  1  25 MHz pixel clock
room_x/room_y  out  clog2(GRID_W)/clog2(GRID_H)  current room
player_x/player_y  out  10 each  player top-left, active-area coordinates

Behaviour:
Clock and reset:
- Everything clocks on CLOCK_50. reset is asynchronous, active-high; clock CLOCK_50.
- tick toggles every cycle and acts as the pixel enable. VGA_CLK = tick.
Reset values:
- Counters 0; room (0,0); player (312,232) = centred.
- All map tiles 4'hF; FSM IDLE.
- RGB 0, HS/VS 1, BLANK_N 0.
Timing generator:
- h counts 0..H_total-1, v counts 0..V_total-1, both advancing on tick.
- Active area: h<H_ACT, v<V_ACT.
- HS low for h in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC); VS low likewise.
- Pixel pipeline is one tick deep. RGB, HS, VS and BLANK_N are all registered with equal latency, so they stay aligned.
Pixel classification, in active-area (x,y):
- Corner squares, where x<WALL or x>=H_ACT-WALL and y<WALL or y>=V_ACT-WALL, are always wall.
- A side band is wall when its mask bit = 0: N is y<WALL, S is y>=V_ACT-WALL, W is x<WALL, E is x>=H_ACT-WALL.
- Colour priority: player (153,51,153) > wall (36,60,0) > floor 0. Outside the active area the colour is 0.
Map:
- Register array. A write applies on the next clock edge and is visible from the next tick, including for the current room mid-frame.
Buttons:
- Two-flop synchronised.
- Priority up > down > left > right; one direction per frame.
Move FSM:
- IDLE → CHECK on the frame tick (tick with v==V_ACT, h==0).
- CHECK computes the candidate position (±STEP on one axis).
- Edge case, where the candidate leaves the screen (y<STEP moving N, y+PSIZE+STEP>V_ACT moving S, same for E/W):
  - If the side is open and the neighbour room is in range → TRANSIT.
  - Otherwise stay, → IDLE.
- Otherwise, candidate box [x,x+PSIZE-1]x[y,y+PSIZE-1] overlapping any wall region → stay. Clear → COMMIT.
- COMMIT updates the position → IDLE.
- TRANSIT steps room_x/room_y by ±1 and places the player at the opposite edge: N gives y=V_ACT-PSIZE, S gives y=0, E gives x=0, W gives x=H_ACT-PSIZE. The other coordinate is kept. → IDLE.
- The FSM finishes within 3 cycles, well inside blanking, so there is no tearing.
- No button pressed: IDLE only.
Reset mid-operation:
- Immediate return to reset values; the map reverts to 4'hF.

Decomposition:
Package meikyuu_pkg holds:
- open-bit indices N/E/S/W
- colour constants
- direction enum
- FSM state enum (IDLE, CHECK, COMMIT, TRANSIT)
- a wall-hit function shared by the pixel path and collision, taking a box, a mask, WALL and the active size

One sub-module: vga_timing_gen, holding the tick, counters, sync, active flag and x/y.

Test Plan:
- Reset, then run one frame → HS low for 96 ticks per 800-tick line, VS low for 2 of 525 lines, 420000 ticks per frame; player at (312,232); pixel (0,0) green, since tile F corners are wall.
- Write tile(0,0)=4'h0, hold btn_left → x falls by 4 per frame to 100 after 53 frames, then stays 100.
- tile(0,0)=4'h5, tile(0,1)=4'h5, hold btn_down → y reaches 464 after 58 frames; next frame room_y=1 and y=0, x still 312.
- Room (0,0) with tile 4'h5, hold btn_up → y reaches 0 after 58 frames, then stays 0 and room_y stays 0 (map edge).
- btn_up and btn_right held together on tile F → only y changes, −4 per frame.
- Write the current room's tile from 4'hF to 4'h0 mid-frame at line 200 → pixel (320,50) is black before the write and green from the next tick after it, N band now wall.
